mem_bus_sequencer: RTL and testbench

- Arbitrates memory access among NREQ requesters (instruction fetch, data stack, return stack) that share the 32-bit data bus and the Memory Address Register (MAR).
- Per transaction: drives the address onto the data bus, commands the MAR to load it, then runs a read or write handshake with memory.
- Sits between the Forth core's requesters and the MAR/memory interface.
- Owns every MAR mode command; no other block writes mar_mode.

---
 rtl/mem_bus_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 29 ++
 rtl/mem_bus_sequencer.sv | 173 +++++++++++++++++
 tb/tb_mem_bus_sequencer.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory bus sequencer.
package mem_bus_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        StClr,
        StIdle,
        StLoad,
        StAccess,
        StDone
    } state_e;

    // MAR mode commands
    localparam logic [1:0] MAR_CLR   = 2'b00;
    localparam logic [1:0] MAR_LOAD  = 2'b01;
    localparam logic [1:0] MAR_DRIVE = 2'b10;  // never issued by the sequencer
    localparam logic [1:0] MAR_HOLD  = 2'b11;

    // Width of a counter that must be able to hold values 0..timeout
    function automatic int unsigned cnt_width(input int unsigned timeout);
        return (timeout < 2) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr+1 (mod NREQ) wins.
module rr_arbiter
    import mem_bus_pkg::*;
#(
    parameter int unsigned NREQ = 3,
    parameter int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [IW-1:0]   o_idx,
    output logic            o_valid
);

    // Search from the slot after the last winner, wrapping once around
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            if (!o_valid && i_req[IW'((32'(i_ptr) + k) % NREQ)]) begin
                o_valid = 1'b1;
                o_idx   = IW'((32'(i_ptr) + k) % NREQ);
                o_gnt[IW'((32'(i_ptr) + k) % NREQ)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_bus_sequencer.sv
// Arbitrates requesters onto the shared bus/MAR and runs the memory handshake.
module mem_bus_sequencer
    import mem_bus_pkg::*;
#(
    parameter int unsigned NREQ    = 3,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_we,
    input  logic [32*NREQ-1:0] req_addr,
    input  logic [32*NREQ-1:0] req_wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic               err,
    output logic [31:0]        rdata,
    output logic [1:0]         mar_mode,
    output logic               bus_oe,
    output logic [31:0]        bus_out,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic [31:0]        mem_wdata,
    input  logic [31:0]        mem_rdata,
    input  logic               mem_ready
);

    localparam int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CntW = cnt_width(TIMEOUT);

    state_e            r_state;
    logic [IW-1:0]     r_ptr;
    logic              r_we;
    logic [31:0]       r_wdata;
    logic [CntW-1:0]   r_cnt;
    logic [NREQ-1:0]   r_gnt;
    logic [NREQ-1:0]   r_done;
    logic              r_err;
    logic [31:0]       r_rdata;
    logic [1:0]        r_mar_mode;
    logic              r_bus_oe;
    logic [31:0]       r_bus_out;
    logic              r_mem_rd;
    logic              r_mem_wr;
    logic [31:0]       r_mem_wdata;

    logic [NREQ-1:0]   w_gnt;
    logic [IW-1:0]     w_idx;
    logic              w_valid;
    logic [31:0]       w_sel_addr;
    logic [31:0]       w_sel_wdata;
    logic              w_sel_we;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_gnt   (w_gnt),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );

    // Mux the winning requester's fields out of the flattened buses
    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_we    = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_idx == IW'(i)) begin
                w_sel_addr  = req_addr[32*i +: 32];
                w_sel_wdata = req_wdata[32*i +: 32];
                w_sel_we    = req_we[i];
            end
        end
    end

    // Sequencer FSM; every output is registered here
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= StClr;
            r_ptr       <= IW'(NREQ - 1);
            r_we        <= 1'b0;
            r_wdata     <= '0;
            r_cnt       <= '0;
            r_gnt       <= '0;
            r_done      <= '0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
            r_mar_mode  <= MAR_CLR;
            r_bus_oe    <= 1'b0;
            r_bus_out   <= '0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_wdata <= '0;
        end else begin
            r_done <= '0;
            unique case (r_state)
                StClr: begin
                    r_mar_mode <= MAR_HOLD;
                    r_state    <= StIdle;
                end
                StIdle: begin
                    r_mar_mode <= MAR_HOLD;
                    if (w_valid) begin
                        // Latch everything now; requester changes after grant are ignored
                        r_ptr      <= w_idx;
                        r_we       <= w_sel_we;
                        r_wdata    <= w_sel_wdata;
                        r_gnt      <= w_gnt;
                        r_bus_oe   <= 1'b1;
                        r_bus_out  <= w_sel_addr;
                        r_mar_mode <= MAR_LOAD;
                        r_state    <= StLoad;
                    end
                end
                StLoad: begin
                    r_bus_oe    <= 1'b0;
                    r_mar_mode  <= MAR_HOLD;
                    r_mem_rd    <= !r_we;
                    r_mem_wr    <= r_we;
                    r_mem_wdata <= r_wdata;
                    r_cnt       <= '0;
                    r_state     <= StAccess;
                end
                StAccess: begin
                    // mem_ready has priority over an expiring timeout
                    if (mem_ready) begin
                        r_mem_rd <= 1'b0;
                        r_mem_wr <= 1'b0;
                        if (!r_we) begin
                            r_rdata <= mem_rdata;
                        end
                        r_err   <= 1'b0;
                        r_done  <= r_gnt;
                        r_state <= StDone;
                    end else if (r_cnt == CntW'(TIMEOUT - 1)) begin
                        r_mem_rd <= 1'b0;
                        r_mem_wr <= 1'b0;
                        r_err    <= 1'b1;
                        r_rdata  <= '0;
                        r_done   <= r_gnt;
                        r_state  <= StDone;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StDone: begin
                    r_gnt   <= '0;
                    r_err   <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StClr;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign done      = r_done;
    assign err       = r_err;
    assign rdata     = r_rdata;
    assign mar_mode  = r_mar_mode;
    assign bus_oe    = r_bus_oe;
    assign bus_out   = r_bus_out;
    assign mem_rd    = r_mem_rd;
    assign mem_wr    = r_mem_wr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_bus_sequencer.sv
// Self-checking bench: MAR + memory model, done-scoreboard, one task per scenario.
module tb_mem_bus_sequencer;

    localparam int unsigned NREQ    = 3;
    localparam int unsigned TIMEOUT = 8;

    logic          clock   = 1'b0;
    logic          reset_n = 1'b1;
    logic [2:0]    req       = '0;
    logic [2:0]    req_we    = '0;
    logic [95:0]   req_addr  = '0;
    logic [95:0]   req_wdata = '0;
    logic [2:0]    gnt;
    logic [2:0]    done;
    logic          err;
    logic [31:0]   rdata;
    logic [1:0]    mar_mode;
    logic          bus_oe;
    logic [31:0]   bus_out;
    logic          mem_rd;
    logic          mem_wr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          mem_ready = 1'b0;

    int n_vec  = 0;
    int n_fail = 0;

    // Memory/MAR model controls
    logic [31:0] mar        = 32'hFFFF_FFFF;
    int          ready_delay = 1;   // ready in Nth ACCESS cycle; 0 = never
    int          acc_cnt     = 0;
    logic        use_fixed   = 1'b0;
    logic [31:0] fixed_val   = '0;

    typedef struct packed {
        logic [2:0]  onehot;
        logic        err;
        logic [31:0] rdata;
    } exp_t;
    exp_t exp_q[$];

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    assign mem_rdata = use_fixed ? fixed_val : mem_fn(mar);

    mem_bus_sequencer #(
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .mar_mode  (mar_mode),
        .bus_oe    (bus_oe),
        .bus_out   (bus_out),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clock = ~clock;

    // MAR register model driven by mar_mode
    always @(posedge clock) begin
        if (reset_n) begin
            if (mar_mode == 2'b00) mar <= '0;
            else if (mar_mode == 2'b01 && bus_oe) mar <= bus_out;
        end
    end

    // Memory responder: raises mem_ready in the chosen ACCESS cycle
    always @(negedge clock) begin
        if (mem_rd || mem_wr) begin
            acc_cnt   = acc_cnt + 1;
            mem_ready = (ready_delay != 0) && (acc_cnt == ready_delay);
        end else begin
            acc_cnt   = 0;
            mem_ready = 1'b0;
        end
    end

    // Scoreboard: each done pulse pops and checks one expected completion
    always @(negedge clock) begin
        exp_t e;
        if (reset_n && done !== 3'b000) begin
            if (exp_q.size() == 0) begin
                n_vec++; n_fail++;
                $display("FAIL unexpected_done: got done=%b, want none", done);
            end else begin
                e = exp_q.pop_front();
                n_vec++;
                if (done !== e.onehot || gnt !== e.onehot) begin
                    n_fail++;
                    $display("FAIL sb_done: got done=%b gnt=%b, want %b", done, gnt, e.onehot);
                end
                n_vec++;
                if (err !== e.err) begin
                    n_fail++;
                    $display("FAIL sb_err: got %b, want %b", err, e.err);
                end
                n_vec++;
                if (rdata !== e.rdata) begin
                    n_fail++;
                    $display("FAIL sb_rdata: got %h, want %h", rdata, e.rdata);
                end
            end
        end
    end

    task automatic test_reset();
        reset_n = 1'b0;
        req     = '0;
        repeat (3) @(negedge clock);
        n_vec++;
        if ({gnt, done, err} !== 7'd0) begin
            n_fail++; $display("FAIL rst_ctl: got %b, want 0", {gnt, done, err});
        end
        n_vec++;
        if (rdata !== 32'd0) begin
            n_fail++; $display("FAIL rst_rdata: got %h, want 0", rdata);
        end
        n_vec++;
        if (mar_mode !== 2'b00) begin
            n_fail++; $display("FAIL rst_mar_mode: got %b, want 00", mar_mode);
        end
        n_vec++;
        if ({bus_oe, mem_rd, mem_wr} !== 3'b000) begin
            n_fail++; $display("FAIL rst_strobes: got %b, want 000", {bus_oe, mem_rd, mem_wr});
        end
        n_vec++;
        if (bus_out !== 32'd0 || mem_wdata !== 32'd0) begin
            n_fail++; $display("FAIL rst_data: got %h/%h, want 0/0", bus_out, mem_wdata);
        end
        reset_n = 1'b1;
        #1;
        n_vec++;
        if (mar_mode !== 2'b00) begin
            n_fail++; $display("FAIL clr_mode: got %b, want 00", mar_mode);
        end
        @(negedge clock);
        n_vec++;
        if (mar_mode !== 2'b11) begin
            n_fail++; $display("FAIL idle_mode: got %b, want 11", mar_mode);
        end
        n_vec++;
        if (mar !== 32'd0) begin
            n_fail++; $display("FAIL mar_cleared: got %h, want 0", mar);
        end
        @(negedge clock);
    endtask

    task automatic test_single_read();
        use_fixed   = 1'b1;
        fixed_val   = 32'hDEAD_BEEF;
        ready_delay = 1;
        req_we[0]   = 1'b0;
        req_addr[31:0] = 32'h0000_0100;
        exp_q.push_back('{onehot: 3'b001, err: 1'b0, rdata: 32'hDEAD_BEEF});
        req[0] = 1'b1;
        @(negedge clock);  // cycle 1: LOAD
        n_vec++;
        if (gnt !== 3'b001 || bus_oe !== 1'b1 || bus_out !== 32'h100 || mar_mode !== 2'b01) begin
            n_fail++;
            $display("FAIL rd_load: got gnt=%b oe=%b bus=%h mode=%b, want 001 1 00000100 01",
                     gnt, bus_oe, bus_out, mar_mode);
        end
        @(negedge clock);  // cycle 2: ACCESS
        n_vec++;
        if (mem_rd !== 1'b1 || mem_wr !== 1'b0 || bus_oe !== 1'b0 || mar_mode !== 2'b11) begin
            n_fail++;
            $display("FAIL rd_access: got rd=%b wr=%b oe=%b mode=%b, want 1 0 0 11",
                     mem_rd, mem_wr, bus_oe, mar_mode);
        end
        @(negedge clock);  // cycle 3: DONE
        n_vec++;
        if (done !== 3'b001) begin
            n_fail++; $display("FAIL rd_latency: got done=%b, want 001", done);
        end
        req[0] = 1'b0;
        @(negedge clock);
        n_vec++;
        if (gnt !== 3'b000 || done !== 3'b000 || err !== 1'b0) begin
            n_fail++; $display("FAIL rd_release: got %b, want 0", {gnt, done, err});
        end
        n_vec++;
        if (mar !== 32'h100) begin
            n_fail++; $display("FAIL rd_mar: got %h, want 00000100", mar);
        end
        use_fixed = 1'b0;
    endtask

    task automatic test_write_wait();
        int wr_cycles = 0;
        int ndone     = 0;
        ready_delay = 4;
        req_we[1]   = 1'b1;
        req_addr[63:32]  = 32'h0000_0200;
        req_wdata[63:32] = 32'h1234_5678;
        exp_q.push_back('{onehot: 3'b010, err: 1'b0, rdata: 32'hDEAD_BEEF});
        req[1] = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clock);
            if (mem_wr === 1'b1) begin
                wr_cycles++;
                n_vec++;
                if (mem_wdata !== 32'h1234_5678) begin
                    n_fail++; $display("FAIL wr_wdata: got %h, want 12345678", mem_wdata);
                end
            end
            if (mem_rd === 1'b1) begin
                n_vec++; n_fail++;
                $display("FAIL wr_no_rd: got mem_rd=1, want 0");
            end
            if (done !== 3'b000) begin
                ndone++;
                req[1]    = 1'b0;
                req_we[1] = 1'b0;
            end
        end
        n_vec++;
        if (wr_cycles != 4) begin
            n_fail++; $display("FAIL wr_cycles: got %0d, want 4", wr_cycles);
        end
        n_vec++;
        if (ndone != 1) begin
            n_fail++; $display("FAIL wr_done_count: got %0d, want 1", ndone);
        end
    endtask

    task automatic test_timeout();
        int  rd_cycles = 0;
        int  ndone     = 0;
        logic prev_done = 1'b0;
        ready_delay = 0;
        req_we[2]   = 1'b0;
        req_addr[95:64] = 32'h0000_0300;
        exp_q.push_back('{onehot: 3'b100, err: 1'b1, rdata: 32'd0});
        req[2] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (prev_done) begin
                n_vec++;
                if (err !== 1'b0 || gnt !== 3'b000) begin
                    n_fail++; $display("FAIL to_clear: got err=%b gnt=%b, want 0 000", err, gnt);
                end
            end
            prev_done = (done !== 3'b000);
            if (mem_rd === 1'b1) rd_cycles++;
            if (done !== 3'b000) begin
                ndone++;
                req[2] = 1'b0;
            end
        end
        n_vec++;
        if (rd_cycles != 8) begin
            n_fail++; $display("FAIL to_cycles: got %0d, want 8", rd_cycles);
        end
        n_vec++;
        if (ndone != 1) begin
            n_fail++; $display("FAIL to_done_count: got %0d, want 1", ndone);
        end
    endtask

    task automatic test_round_robin();
        int last  = -1;
        int ndone = 0;
        ready_delay = 1;
        req_we = 3'b000;
        req_addr[31:0]  = 32'h0000_1000;
        req_addr[63:32] = 32'h0000_2000;
        req_addr[95:64] = 32'h0000_3000;
        exp_q.push_back('{onehot: 3'b001, err: 1'b0, rdata: mem_fn(32'h0000_1000)});
        exp_q.push_back('{onehot: 3'b010, err: 1'b0, rdata: mem_fn(32'h0000_2000)});
        exp_q.push_back('{onehot: 3'b100, err: 1'b0, rdata: mem_fn(32'h0000_3000)});
        exp_q.push_back('{onehot: 3'b001, err: 1'b0, rdata: mem_fn(32'h0000_1000)});
        req = 3'b111;
        for (int c = 0; c < 24; c++) begin
            @(negedge clock);
            if (done !== 3'b000) begin
                if (last >= 0) begin
                    n_vec++;
                    if (c - last != 4) begin
                        n_fail++; $display("FAIL rr_period: got %0d, want 4", c - last);
                    end
                end
                last = c;
                ndone++;
                if (ndone == 4) req = 3'b000;
            end
        end
        n_vec++;
        if (ndone != 4) begin
            n_fail++; $display("FAIL rr_done_count: got %0d, want 4", ndone);
        end
    endtask

    task automatic test_reset_mid();
        int  ndone = 0;
        bit  seen  = 0;
        ready_delay = 0;
        req_we[0]   = 1'b0;
        req_addr[31:0] = 32'h0000_0400;
        req[0] = 1'b1;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clock);
            if (mem_rd === 1'b1) seen = 1;
        end
        n_vec++;
        if (!seen) begin
            n_fail++; $display("FAIL mid_reach_access: got no mem_rd, want mem_rd=1");
        end
        reset_n = 1'b0;
        #1;
        n_vec++;
        if (mem_rd !== 1'b0 || gnt !== 3'b000 || bus_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_async: got rd=%b gnt=%b oe=%b, want 0 000 0", mem_rd, gnt, bus_oe);
        end
        req[0] = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        #1;
        n_vec++;
        if (mar_mode !== 2'b00) begin
            n_fail++; $display("FAIL mid_clr: got %b, want 00", mar_mode);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            if (done !== 3'b000) ndone++;
        end
        n_vec++;
        if (mar_mode !== 2'b11 || gnt !== 3'b000) begin
            n_fail++; $display("FAIL mid_idle: got mode=%b gnt=%b, want 11 000", mar_mode, gnt);
        end
        n_vec++;
        if (ndone != 0) begin
            n_fail++; $display("FAIL mid_no_done: got %0d, want 0", ndone);
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_single_read();
        test_write_wait();
        test_timeout();
        test_round_robin();
        test_reset_mid();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL sb_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
